bulls_cows_core_p: RTL and testbench

Parametrised game core for the Bulls-and-Cows design, successor to the fixed 4-digit/3-bit core. Holds the secret code, accepts guesses on a `save` press, scores each guess sequentially into bulls and cows, counts attempts against a limit, and reports win/lose. It sits under the Tiny Tapeout wrapper, between the switch inputs and the 7-segment display driver, which remains outside this block.

---
 rtl/bc_pkg.sv | 40 ++++
 rtl/bc_sync_edge.sv | 22 ++
 rtl/bulls_cows_core_p.sv | 158 +++++++++++++++
 tb/tb_bulls_cows_core_p.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/bc_pkg.sv
// Shared types and helpers for the Bulls-and-Cows game core.
package bc_pkg;

  typedef enum logic [2:0] {
    StSetSecret = 3'd0,
    StGuess     = 3'd1,
    StScore     = 3'd2,
    StReport    = 3'd3,
    StWin       = 3'd4,
    StLose      = 3'd5
  } bc_state_e;

  localparam int unsigned MaxDigits = 16;
  localparam int unsigned MaxCodeW  = 64;

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Code is zero-extended into a fixed-width container so one function serves every parameter set.
  function automatic logic has_dup(input logic [MaxCodeW-1:0] code,
                                   input int unsigned n_digits,
                                   input int unsigned digit_w);
    logic [MaxCodeW-1:0] mask;
    logic [MaxCodeW-1:0] di;
    logic [MaxCodeW-1:0] dj;
    logic dup;
    dup  = 1'b0;
    mask = (MaxCodeW'(1) << digit_w) - MaxCodeW'(1);
    for (int unsigned i = 0; i < MaxDigits; i++) begin
      for (int unsigned j = i + 1; j < MaxDigits; j++) begin
        di = (code >> (i * digit_w)) & mask;
        dj = (code >> (j * digit_w)) & mask;
        if (j < n_digits && di == dj) dup = 1'b1;
      end
    end
    return dup;
  endfunction

endpackage

// File: rtl/bc_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector for the save button.
module bc_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic evt_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], async_i};
    end
  end

  // sync_q[2] only remembers the previous synchronised level for edge detection.
  assign evt_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/bulls_cows_core_p.sv
// Parametrised Bulls-and-Cows game core: secret/guess entry, sequential scoring, win/lose.
module bulls_cows_core_p
  import bc_pkg::*;
#(
  parameter int unsigned N_DIGITS  = 4,
  parameter int unsigned DIGIT_W   = 3,
  parameter int unsigned MAX_TRIES = 8,
  localparam int unsigned CW       = cnt_w(N_DIGITS),
  localparam int unsigned CodeW    = N_DIGITS * DIGIT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [CodeW-1:0] code_i,
  input  logic             save_i,
  output logic [2:0]       state_o,
  output logic [CW-1:0]    bulls_o,
  output logic [CW-1:0]    cows_o,
  output logic [7:0]       tries_o,
  output logic             result_valid_o,
  output logic             win_o,
  output logic             lose_o,
  output logic             err_dup_o
);

  localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  if (N_DIGITS > 2 ** DIGIT_W) begin : g_no_valid_code
    $error("N_DIGITS exceeds the number of distinct digit values");
  end
  if (N_DIGITS > MaxDigits || CodeW > MaxCodeW) begin : g_too_wide
    $error("code too wide for has_dup container");
  end
  if (MAX_TRIES < 1 || MAX_TRIES > 255) begin : g_bad_tries
    $error("MAX_TRIES must be within 1..255");
  end

  bc_state_e        state_q, state_d;
  logic [CodeW-1:0] secret_q, secret_d;
  logic [CodeW-1:0] guess_q, guess_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [CW-1:0]    bulls_q, bulls_d;
  logic [CW-1:0]    cows_q, cows_d;
  logic [7:0]       tries_q, tries_d;
  logic             err_dup_q, err_dup_d;
  logic             save_evt;
  logic             code_dup;
  logic [DIGIT_W-1:0] g_dig;
  logic             hit_bull;
  logic             hit_cow;

  bc_sync_edge u_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .async_i (save_i),
    .evt_o   (save_evt)
  );

  always_comb begin
    code_dup = has_dup(MaxCodeW'(code_i), N_DIGITS, DIGIT_W);
    g_dig    = guess_q[idx_q*DIGIT_W +: DIGIT_W];
    hit_bull = (g_dig == secret_q[idx_q*DIGIT_W +: DIGIT_W]);
    hit_cow  = 1'b0;
    for (int unsigned j = 0; j < N_DIGITS; j++) begin
      if (g_dig == secret_q[j*DIGIT_W +: DIGIT_W]) hit_cow = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    secret_d  = secret_q;
    guess_d   = guess_q;
    idx_d     = idx_q;
    bulls_d   = bulls_q;
    cows_d    = cows_q;
    tries_d   = tries_q;
    err_dup_d = 1'b0;
    unique case (state_q)
      StSetSecret: begin
        if (save_evt) begin
          if (code_dup) begin
            err_dup_d = 1'b1;
          end else begin
            secret_d = code_i;
            tries_d  = 8'd0;
            bulls_d  = '0;
            cows_d   = '0;
            state_d  = StGuess;
          end
        end
      end
      StGuess: begin
        if (save_evt) begin
          if (code_dup) begin
            err_dup_d = 1'b1;
          end else begin
            guess_d = code_i;
            bulls_d = '0;
            cows_d  = '0;
            idx_d   = '0;
            state_d = StScore;
          end
        end
      end
      StScore: begin
        if (hit_bull) bulls_d = bulls_q + CW'(1);
        else if (hit_cow) cows_d = cows_q + CW'(1);
        // Count the try on REPORT entry so tries_o is already current while result_valid_o is high.
        if (idx_q == IdxW'(N_DIGITS - 1)) begin
          tries_d = tries_q + 8'd1;
          state_d = StReport;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StReport: begin
        if (bulls_q == CW'(N_DIGITS)) state_d = StWin;
        else if (tries_q == 8'(MAX_TRIES)) state_d = StLose;
        else state_d = StGuess;
      end
      StWin, StLose: begin
        if (save_evt) state_d = StSetSecret;
      end
      default: state_d = StSetSecret;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StSetSecret;
      secret_q  <= '0;
      guess_q   <= '0;
      idx_q     <= '0;
      bulls_q   <= '0;
      cows_q    <= '0;
      tries_q   <= 8'd0;
      err_dup_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      secret_q  <= secret_d;
      guess_q   <= guess_d;
      idx_q     <= idx_d;
      bulls_q   <= bulls_d;
      cows_q    <= cows_d;
      tries_q   <= tries_d;
      err_dup_q <= err_dup_d;
    end
  end

  assign state_o        = state_q;
  assign bulls_o        = bulls_q;
  assign cows_o         = cows_q;
  assign tries_o        = tries_q;
  assign result_valid_o = (state_q == StReport);
  assign win_o          = (state_q == StWin);
  assign lose_o         = (state_q == StLose);
  assign err_dup_o      = err_dup_q;

endmodule

// File: tb/tb_bulls_cows_core_p.sv
// Directed bench for bulls_cows_core_p with 4 digits, 3-bit digits, 3 tries.
module tb_bulls_cows_core_p;

  logic        clk_i;
  logic        rst_ni;
  logic [11:0] code_i;
  logic        save_i;
  logic [2:0]  state_o;
  logic [2:0]  bulls_o;
  logic [2:0]  cows_o;
  logic [7:0]  tries_o;
  logic        result_valid_o;
  logic        win_o;
  logic        lose_o;
  logic        err_dup_o;

  int n_vec;
  int n_bad;
  int rv_cnt;

  bulls_cows_core_p #(
    .N_DIGITS  (4),
    .DIGIT_W   (3),
    .MAX_TRIES (3)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .code_i         (code_i),
    .save_i         (save_i),
    .state_o        (state_o),
    .bulls_o        (bulls_o),
    .cows_o         (cows_o),
    .tries_o        (tries_o),
    .result_valid_o (result_valid_o),
    .win_o          (win_o),
    .lose_o         (lose_o),
    .err_dup_o      (err_dup_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] enc(input int d3, input int d2, input int d1, input int d0);
    return {3'(d3), 3'(d2), 3'(d1), 3'(d0)};
  endfunction

  // Leaves the bench in the cycle right after the FSM's acting edge; code_i is then scrambled.
  task automatic press(input logic [11:0] code);
    code_i = code;
    save_i = 1'b1;
    @(negedge clk_i);
    save_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    code_i = 12'hfff;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      if (result_valid_o) rv_cnt++;
    end
  endtask

  initial begin
    n_vec  = 0;
    n_bad  = 0;
    rv_cnt = 0;
    rst_ni = 1'b0;
    save_i = 1'b0;
    code_i = 12'd0;
    repeat (3) @(negedge clk_i);
    check_eq("rst_state", 32'(state_o), 32'd0);
    check_eq("rst_outs", {bulls_o, cows_o, tries_o, result_valid_o, win_o, lose_o, err_dup_o},
             32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Secret 1234, guess 1243
    press(enc(1, 2, 3, 4));
    check_eq("secret_state", 32'(state_o), 32'd1);
    check_eq("secret_nodup", 32'(err_dup_o), 32'd0);
    press(enc(1, 2, 4, 3));
    check_eq("score_state", 32'(state_o), 32'd2);
    wait_cycles(3);
    check_eq("rv_not_early", 32'(result_valid_o), 32'd0);
    @(negedge clk_i);
    check_eq("rv_1243", 32'(result_valid_o), 32'd1);
    check_eq("bulls_1243", 32'(bulls_o), 32'd2);
    check_eq("cows_1243", 32'(cows_o), 32'd2);
    check_eq("tries_1243", 32'(tries_o), 32'd1);
    @(negedge clk_i);
    check_eq("back_guess", 32'(state_o), 32'd1);
    check_eq("rv_one_cycle", 32'(result_valid_o), 32'd0);

    // Winning guess
    press(enc(1, 2, 3, 4));
    wait_cycles(4);
    check_eq("bulls_win", 32'(bulls_o), 32'd4);
    check_eq("cows_win", 32'(cows_o), 32'd0);
    @(negedge clk_i);
    check_eq("win_state", 32'(state_o), 32'd4);
    check_eq("win_flag", 32'(win_o), 32'd1);
    press(enc(0, 1, 2, 3));
    check_eq("win_to_set", 32'(state_o), 32'd0);
    check_eq("win_cleared", 32'(win_o), 32'd0);
    check_eq("bulls_kept", 32'(bulls_o), 32'd4);

    // Secret 0123, three misses -> LOSE
    press(enc(0, 1, 2, 3));
    check_eq("secret2_state", 32'(state_o), 32'd1);
    check_eq("tries_cleared", 32'(tries_o), 32'd0);
    for (int t = 1; t <= 3; t++) begin
      press(enc(4, 5, 6, 7));
      wait_cycles(4);
      check_eq("miss_rv", 32'(result_valid_o), 32'd1);
      check_eq("miss_bc", {bulls_o, cows_o}, 32'd0);
      check_eq("miss_tries", 32'(tries_o), 32'(t));
      @(negedge clk_i);
      check_eq("miss_next", 32'(state_o), (t == 3) ? 32'd5 : 32'd1);
    end
    check_eq("lose_flag", 32'(lose_o), 32'd1);
    check_eq("lose_tries", 32'(tries_o), 32'd3);
    press(enc(0, 0, 0, 0));
    check_eq("lose_to_set", 32'(state_o), 32'd0);
    check_eq("lose_cleared", 32'(lose_o), 32'd0);

    // Duplicate rejection
    press(enc(1, 1, 2, 3));
    check_eq("dup_secret_err", 32'(err_dup_o), 32'd1);
    check_eq("dup_secret_state", 32'(state_o), 32'd0);
    @(negedge clk_i);
    check_eq("dup_err_pulse", 32'(err_dup_o), 32'd0);
    press(enc(1, 2, 3, 4));
    check_eq("secret3_state", 32'(state_o), 32'd1);
    press(enc(5, 5, 2, 1));
    check_eq("dup_guess_err", 32'(err_dup_o), 32'd1);
    check_eq("dup_guess_state", 32'(state_o), 32'd1);
    check_eq("dup_guess_tries", 32'(tries_o), 32'd0);

    // save held high for 50 cycles
    rv_cnt = 0;
    code_i = enc(1, 2, 4, 3);
    save_i = 1'b1;
    wait_cycles(50);
    save_i = 1'b0;
    wait_cycles(10);
    check_eq("held_rv_count", 32'(rv_cnt), 32'd1);
    check_eq("held_tries", 32'(tries_o), 32'd1);
    check_eq("held_state", 32'(state_o), 32'd1);

    // Reset during second SCORE cycle
    press(enc(1, 2, 4, 3));
    @(negedge clk_i);
    check_eq("mid_score_state", 32'(state_o), 32'd2);
    rst_ni = 1'b0;
    #1;
    check_eq("mrst_state", 32'(state_o), 32'd0);
    check_eq("mrst_bc", {bulls_o, cows_o}, 32'd0);
    check_eq("mrst_tries", 32'(tries_o), 32'd0);
    rv_cnt = 0;
    wait_cycles(2);
    rst_ni = 1'b1;
    wait_cycles(10);
    check_eq("mrst_no_rv", 32'(rv_cnt), 32'd0);
    check_eq("mrst_state_after", 32'(state_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
